// File: rtl/avalon_mem_pkg.sv
// Shared definitions for the Avalon wait-state RAM.
// Contents:
//   wait_state_e - bus FSM states (IDLE / WAIT / ACK)
//   AVL_DATA_W   - Avalon data width (32)
//   AVL_BE_W     - byte-enable width (4)
//   merge_bytes  - byte-lane merge of a new word into an old word
package avalon_mem_pkg;

  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wait_state_e;

  // Lanes with be[i]=1 take new_word, the rest keep old_word.
  function automatic logic [AVL_DATA_W-1:0] merge_bytes(
    input logic [AVL_DATA_W-1:0] old_word,
    input logic [AVL_DATA_W-1:0] new_word,
    input logic [AVL_BE_W-1:0]   be
  );
    logic [AVL_DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < AVL_BE_W; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/avalon_wait_ctrl.sv
// Wait-state controller for avalon_wait_ram: FSM, wait counter and the
// combinational waitrequest.
//
// Handshake: a transfer completes on a rising edge where req is high and
// waitrequest is low; the master keeps its request and qualifiers stable
// while waitrequest is high.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   req           - read or write request present
//   load_en       - backdoor load strobe; stalls the bus and freezes the FSM
//   waitrequest   - slave stall (combinational)
//   ack           - FSM is in ACK (transfer may complete this cycle)
//   drop_err      - request dropped while waiting (protocol violation)
//   state_dbg     - current FSM state, for observation
//   count_dbg     - current wait counter, for observation
module avalon_wait_ctrl
  import avalon_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       load_en,
  output logic       waitrequest,
  output logic       ack,
  output logic       drop_err,
  output logic [1:0] state_dbg,
  output logic [3:0] count_dbg
);

  wait_state_e state;
  logic [3:0]  count;

  // The IDLE cycle that sees the request is itself the first wait state,
  // so WAIT lasts WAIT_CYCLES-1 cycles; the counter reaches 0 on the
  // edge that enters ACK. With a single wait state WAIT is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 4'd0;
    end else if (!load_en) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (WAIT_CYCLES <= 1) begin
              state <= ACK;
              count <= 4'd0;
            end else begin
              state <= WAIT;
              count <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (!req) begin
            state <= IDLE;
            count <= 4'd0;
          end else if (count <= 4'd1) begin
            state <= ACK;
            count <= 4'd0;
          end else begin
            count <= count - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ack         = (state == ACK);
  assign waitrequest = load_en | (req & (state != ACK));
  assign drop_err    = (state == WAIT) & ~req & ~load_en;
  assign state_dbg   = state;
  assign count_dbg   = count;

endmodule

// File: rtl/avalon_wait_ram.sv
// Avalon-MM slave RAM of DEPTH_WORDS 32-bit words with optional wait states
// and a backdoor preload port.
//
// Build option: define AVALON_WAIT_RAM_WAITSTATES_EN to insert WAIT_CYCLES
// wait states per transfer through avalon_wait_ctrl. Without it transfers
// are zero-latency: reads are combinational, writes commit at the same edge.
//
// Handshake: a transfer completes on a rising edge where read or write is
// high and waitrequest is low; address, writedata and byteenable are used
// at that edge and must be held stable while waitrequest is high.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset (clears memory)
//   address       - byte address, word aligned, relative to BASE_ADDR
//   read, write   - requests; both high is treated as a write and flagged
//   writedata     - write data
//   byteenable    - write lanes, bit i -> bits 8i+7:8i
//   waitrequest   - slave stall
//   readdata      - read word on the completing cycle, 0 otherwise
//   load_en       - backdoor preload strobe (stalls the bus)
//   load_addr     - backdoor byte address, word load_addr[7:2]
//   load_data     - backdoor word, all bytes written
//   protocol_err  - sticky flag: misaligned/out-of-range access,
//                   read+write together, or request dropped mid-wait
module avalon_wait_ram
  import avalon_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic                  read,
  input  logic                  write,
  input  logic [AVL_DATA_W-1:0] writedata,
  input  logic [AVL_BE_W-1:0]   byteenable,
  output logic                  waitrequest,
  output logic [AVL_DATA_W-1:0] readdata,
  input  logic                  load_en,
  input  logic [7:0]            load_addr,
  input  logic [AVL_DATA_W-1:0] load_data,
  output logic                  protocol_err
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  logic [AVL_DATA_W-1:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      load_word;
  logic [IDX_W-1:0] load_idx;
  logic             req;
  logic             complete;
  logic             violation;
  logic             unused_bits;

  // An address below BASE_ADDR wraps to a huge offset and lands out of range.
  assign offset    = address - BASE_ADDR;
  assign in_range  = ({1'b0, offset} < SPAN) && (address[1:0] == 2'b00);
  assign word_idx  = offset[IDX_W+1:2];
  assign load_word = {26'd0, load_addr[7:2]};
  assign load_idx  = load_word[IDX_W-1:0];
  assign req       = read | write;

`ifdef AVALON_WAIT_RAM_WAITSTATES_EN
  logic       ack;
  logic       drop_err;
  logic [1:0] state_dbg;
  logic [3:0] count_dbg;

  avalon_wait_ctrl #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .load_en    (load_en),
    .waitrequest(waitrequest),
    .ack        (ack),
    .drop_err   (drop_err),
    .state_dbg  (state_dbg),
    .count_dbg  (count_dbg)
  );

  assign complete    = req & ack & ~load_en;
  assign violation   = drop_err | (complete & ((read & write) | ~in_range));
  assign unused_bits = ^{load_addr[1:0], load_word, state_dbg, count_dbg};
`else
  assign waitrequest = load_en;
  assign complete    = req & ~load_en;
  assign violation   = complete & ((read & write) | ~in_range);
  assign unused_bits = ^{load_addr[1:0], load_word};
`endif

  // A read collapsed into a write returns 0 rather than the old word.
  always_comb begin
    readdata = '0;
    if (complete && read && !write && in_range) readdata = mem[word_idx];
  end

  // Reset clears storage before anything else; the backdoor cannot collide
  // with a bus commit because load_en holds waitrequest high.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (load_en) begin
        mem[load_idx] <= load_data;
      end else if (complete && write && in_range) begin
        mem[word_idx] <= merge_bytes(mem[word_idx], writedata, byteenable);
      end
      if (violation) protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
module tb_avalon_wait_ram;

`ifdef AVALON_WAIT_RAM_WAITSTATES_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        protocol_err;

  int n_cmp = 0;
  int n_bad = 0;
  int wcnt  = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  avalon_wait_ram #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .protocol_err(protocol_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- driver tasks (entered at posedge+1) ----------------
  task automatic xfer(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic [31:0] exp_rd);
    bit done;
    exp_q.push_back(exp_rd);
    lat_q.push_back(LAT);
    read = r; write = w; address = a; writedata = d; byteenable = be;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!waitrequest) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL xfer_timeout: addr %h still stalled after 40 cycles, expected completion", a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    read = 1'b0; write = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    #1 check("load_waitrequest", {31'd0, waitrequest}, 32'd1);
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      wcnt = 0;
    end else if ((read || write) && !waitrequest) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_xfer: addr %h completed, expected no transfer", address);
      end else begin
        check("readdata", readdata, exp_q.pop_front());
        check("wait_states", 32'(wcnt), 32'(lat_q.pop_front()));
      end
      wcnt = 0;
    end else begin
      if ((read || write) && waitrequest) wcnt++;
      check("readdata_zero", readdata, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    byteenable = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_waitrequest", {31'd0, waitrequest}, 32'd0);
    check("reset_readdata", readdata, 32'h0);
    check("reset_err", {31'd0, protocol_err}, 32'd0);

    preload(8'h04, 32'h2402A234);
    preload(8'h08, 32'h1234_5678);
    xfer(1, 0, 32'h04, 32'h0, 4'hF, 32'h2402A234);
    idle_bus();

    // Byte lanes on word 0x10.
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'b0101, 32'h0);
    xfer(1, 0, 32'h10, 32'h0, 4'b0000, 32'h00AD00EF);
    xfer(0, 1, 32'h10, 32'h11223344, 4'b1010, 32'h0);
    xfer(1, 0, 32'h10, 32'h0, 4'b0001, 32'h11AD33EF);
    xfer(0, 1, 32'h10, 32'hAAAAAAAA, 4'b0000, 32'h0);
    xfer(1, 0, 32'h10, 32'h0, 4'hF, 32'h11AD33EF);
    idle_bus();

    // Back-to-back reads with read held high.
    xfer(1, 0, 32'h04, 32'h0, 4'hF, 32'h2402A234);
    xfer(1, 0, 32'h08, 32'h0, 4'hF, 32'h1234_5678);
    idle_bus();
    check("err_clean", {31'd0, protocol_err}, 32'd0);

    // Out-of-range read, then misaligned write that must not land.
    xfer(1, 0, 32'h400, 32'h0, 4'hF, 32'h0);
    idle_bus();
    check("err_oor", {31'd0, protocol_err}, 32'd1);
    xfer(0, 1, 32'h06, 32'hFFFFFFFF, 4'hF, 32'h0);
    xfer(1, 0, 32'h04, 32'h0, 4'hF, 32'h2402A234);
    xfer(1, 0, 32'hFFFF_FFFC, 32'h0, 4'hF, 32'h0);
    idle_bus();

    // Reset clears the flag and the memory.
    do_reset(1);
    check("err_after_reset", {31'd0, protocol_err}, 32'd0);
    xfer(1, 0, 32'h04, 32'h0, 4'hF, 32'h0);
    idle_bus();

    // Read and write together: write lands, readdata 0, sticky error.
    xfer(1, 1, 32'h0C, 32'hCAFEF00D, 4'hF, 32'h0);
    idle_bus();
    check("err_rw", {31'd0, protocol_err}, 32'd1);
    xfer(1, 0, 32'h0C, 32'h0, 4'hF, 32'hCAFEF00D);
    idle_bus();
    check("err_sticky", {31'd0, protocol_err}, 32'd1);

    // Reset in the middle of a write to 0x20.
    do_reset(1);
    read = 1'b0; write = 1'b1; address = 32'h20; writedata = 32'h1; byteenable = 4'hF;
`ifdef AVALON_WAIT_RAM_WAITSTATES_EN
    @(posedge clk);
    #1 check("inflight_waitrequest", {31'd0, waitrequest}, 32'd1);
    reset = 1'b1;
`else
    reset = 1'b1;
`endif
    @(posedge clk);
    #1 reset = 1'b0; write = 1'b0;
    xfer(1, 0, 32'h20, 32'h0, 4'hF, 32'h0);
    idle_bus();
    check("err_after_inflight", {31'd0, protocol_err}, 32'd0);

    repeat (3) idle_bus();
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
